// File: rtl/load_store_ctrl.sv
// Load/store controller: validates a load or store, runs the memory req/ack
// handshake with a timeout, and returns lane-aligned, extended load data.
module load_store_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ld_req_i,
    input  logic        st_req_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_byte_en_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned F3W = 3;

    localparam logic [1:0]    CAUSE_NONE     = 2'b00;
    localparam logic [1:0]    CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]    CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0]    CAUSE_TIMEOUT  = 2'b11;
    localparam logic [CW-1:0] TIMEOUT_LIM    = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [F3W-1:0]  funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;

    logic            mem_req_d, mem_we_d, done_d, err_d;
    logic [DW-1:0]   mem_addr_d, mem_wdata_d, rdata_d;
    logic [BEW-1:0]  be_d;
    logic [1:0]      cause_d;

    logic            illegal_c, misaligned_c;
    logic [BEW-1:0]  be_c;
    logic [DW-1:0]   wdata_c, load_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;

    assign cnt_inc = cnt_q + CW'(1);

    // Fault classification of the incoming request; illegal takes priority
    always_comb begin
        illegal_c = (ld_req_i & st_req_i)
                  | (ld_req_i & ((funct3_i == 3'b011) | (funct3_i == 3'b110) | (funct3_i == 3'b111)))
                  | (st_req_i & (funct3_i >= 3'b011));
        misaligned_c = ((funct3_i[1:0] == 2'b01) & addr_i[0])
                     | ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
    end

    // Byte-lane enables and replicated store data for the incoming request
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_i[1:0];
                wdata_c = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << addr_i[1:0];
                wdata_c = {2{wdata_i[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wdata_i;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the returned read word
    always_comb begin
        byte_c = mem_rdata_i[7:0];
        case (off_q)
            2'b00:   byte_c = mem_rdata_i[7:0];
            2'b01:   byte_c = mem_rdata_i[15:8];
            2'b10:   byte_c = mem_rdata_i[23:16];
            default: byte_c = mem_rdata_i[31:24];
        endcase
        half_c = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b100:  load_c = {24'd0, byte_c};
            3'b101:  load_c = {16'd0, half_c};
            default: load_c = mem_rdata_i;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        be_d        = '0;
        mem_wdata_d = '0;
        done_d      = 1'b0;
        cause_d     = CAUSE_NONE;
        rdata_d     = '0;
        stall_o     = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = ld_req_i | st_req_i;
                cnt_d   = '0;
                if (ld_req_i | st_req_i) begin
                    funct3_d = funct3_i;
                    off_d    = addr_i[1:0];
                    if (illegal_c) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (misaligned_c) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = st_req_i;
                        mem_addr_d  = {addr_i[31:2], 2'b00};
                        be_d        = be_c;
                        mem_wdata_d = wdata_c;
                    end
                end
            end
            ACCESS: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    rdata_d = mem_we_o ? '0 : load_c;
                end else if (cnt_inc == TIMEOUT_LIM) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d       = cnt_inc;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we_o;
                    mem_addr_d  = mem_addr_o;
                    be_d        = mem_byte_en_o;
                    mem_wdata_d = mem_wdata_o;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        err_d = (cause_d != CAUSE_NONE);
    end

    // State register and captured request fields
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
        end
    end

    // Registered memory-side and pipeline-side outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_byte_en_o <= '0;
            mem_wdata_o   <= '0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            err_cause_o   <= CAUSE_NONE;
            rdata_o       <= '0;
        end else begin
            mem_req_o     <= mem_req_d;
            mem_we_o      <= mem_we_d;
            mem_addr_o    <= mem_addr_d;
            mem_byte_en_o <= be_d;
            mem_wdata_o   <= mem_wdata_d;
            done_o        <= done_d;
            err_o         <= err_d;
            err_cause_o   <= cause_d;
            rdata_o       <= rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: vector table with a completion scoreboard, plus
// hand-written timeout and reset sequences on a short-timeout instance.
module tb_load_store_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ld_req = 1'b0, st_req = 1'b0, ld_b = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, wdata = '0, mrdata = '0;
    logic        mem_ack = 1'b0, mem_ack_b = 1'b0;

    logic        stall, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  cause;
    logic [3:0]  be;

    logic        stall_b, done_b, err_b, mem_req_b, mem_we_b;
    logic [31:0] rdata_b, mem_addr_b, mem_wdata_b;
    logic [1:0]  cause_b;
    logic [3:0]  be_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          delay;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        logic [1:0]  cause;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    load_store_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n), .ld_req_i(ld_req), .st_req_i(st_req),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .stall_o(stall),
        .done_o(done), .rdata_o(rdata), .err_o(err), .err_cause_o(cause),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_byte_en_o(be), .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack),
        .mem_rdata_i(mrdata)
    );

    load_store_ctrl #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .ld_req_i(ld_b), .st_req_i(1'b0),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .stall_o(stall_b),
        .done_o(done_b), .rdata_o(rdata_b), .err_o(err_b), .err_cause_o(cause_b),
        .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
        .mem_byte_en_o(be_b), .mem_wdata_o(mem_wdata_b), .mem_ack_i(mem_ack_b),
        .mem_rdata_i(mrdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest pending result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending transaction at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rdata", rdata, e.rdata);
                chk("sb_err", 32'(err), 32'(e.err));
                chk("sb_cause", 32'(cause), 32'(e.cause));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        ld_req = v.ld; st_req = v.st; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        e.rdata = v.rdata; e.cause = v.cause; e.err = (v.cause != 2'b00);
        sb.push_back(e);
        @(negedge clk);
        chk("stall_c0", 32'(stall), 32'd1);
        chk("req_c0", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        ld_req = 1'b0; st_req = 1'b0;
        if (!v.fault && v.delay == 0) begin mem_ack = 1'b1; mrdata = v.mrdata; end
        @(negedge clk);
        if (v.fault) begin
            chk("fault_done", 32'(done), 32'd1);
            chk("fault_req", 32'(mem_req), 32'd0);
            chk("fault_stall", 32'(stall), 32'd0);
        end else begin
            chk("req_c1", 32'(mem_req), 32'd1);
            chk("stall_c1", 32'(stall), 32'd1);
            chk("we", 32'(mem_we), 32'(v.st));
            chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
            chk("byte_en", 32'(be), 32'(v.be));
            chk("mem_wdata", mem_wdata, v.mwdata);
            for (int d = 1; d <= v.delay; d++) begin
                @(posedge clk); #1;
                if (d == v.delay) begin mem_ack = 1'b1; mrdata = v.mrdata; end
                @(negedge clk);
                chk("req_wait", 32'(mem_req), 32'd1);
                chk("be_wait", 32'(be), 32'(v.be));
                chk("done_wait", 32'(done), 32'd0);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; mrdata = 32'h5A5A_5A5A;
            @(negedge clk);
            chk("done", 32'(done), 32'd1);
            chk("stall_resp", 32'(stall), 32'd0);
            chk("req_resp", 32'(mem_req), 32'd0);
        end
    endtask

    initial begin
        //             ld    st    f3      addr          wdata         mrdata        dly fault be       mwdata        rdata         cause
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 2'b00});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80, 2'b00});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8012_3456, 2, 1'b0, 4'b1000, 32'h0,        32'h0000_0080, 2'b00});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001, 2'b00});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_1234, 1, 1'b0, 4'b1100, 32'h0,        32'h0000_8001, 2'b00});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 1'b0, 4'b0010, 32'h0,        32'h0000_007F, 2'b00});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_56AB, 32'hFFFF_FFFF, 4, 1'b0, 4'b1100, 32'h56AB_56AB, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'h1111_1111, 0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0,        2'b00});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        2'b01});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        2'b01});
        vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        2'b10});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        2'b10});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        2'b10});
        vecs.push_back('{1'b1, 1'b0, 3'b110, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        2'b10});

        #1 rst_n = 1'b0;
        #12;
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", 32'(be), 32'd0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Ack while idle must not start or complete anything
        @(posedge clk); #1 mem_ack = 1'b1; mrdata = 32'h0BAD_0BAD;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_done", 32'(done), 32'd0);
        chk("idle_ack_req", 32'(mem_req), 32'd0);

        // Short-timeout instance, no ack: request cycles 1-4, timeout done in cycle 5
        @(posedge clk); #1 ld_b = 1'b1; funct3 = 3'b010; addr = 32'h200;
        @(posedge clk); #1 ld_b = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("to_req", 32'(mem_req_b), 32'd1);
            chk("to_nodone", 32'(done_b), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_done", 32'(done_b), 32'd1);
        chk("to_err", 32'(err_b), 32'd1);
        chk("to_cause", 32'(cause_b), 32'd3);
        chk("to_req_drop", 32'(mem_req_b), 32'd0);
        chk("to_rdata", rdata_b, 32'h0);

        // Ack arriving in the timeout cycle wins
        @(posedge clk); #1 ld_b = 1'b1; funct3 = 3'b010; addr = 32'h204;
        @(posedge clk); #1 ld_b = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
        end
        mem_ack_b = 1'b1; mrdata = 32'h1122_3344;
        @(negedge clk);
        chk("ackwin_req", 32'(mem_req_b), 32'd1);
        @(posedge clk); #1 mem_ack_b = 1'b0;
        @(negedge clk);
        chk("ackwin_done", 32'(done_b), 32'd1);
        chk("ackwin_err", 32'(err_b), 32'd0);
        chk("ackwin_cause", 32'(cause_b), 32'd0);
        chk("ackwin_rdata", rdata_b, 32'h1122_3344);

        // Reset during ACCESS drops the request at once and produces no done
        @(posedge clk); #1 ld_req = 1'b1; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1 ld_req = 1'b0;
        @(negedge clk);
        chk("rstmid_req_before", 32'(mem_req), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(mem_req), 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstmid_nodone", 32'(done), 32'd0);
        end
        run_vec(vecs[0]);

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
